// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: instruction-memory geometry, HALT marker and load-controller state encoding
package mips_mem_pkg;
    localparam int NB_DATA = 32;
    localparam int NBYTE = 8;
    localparam int N_ELEMENTS = 128;
    localparam int ADDRWIDTH = $clog2(N_ELEMENTS);
    localparam logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        WRITE = ST_WRITE,
        DONE = ST_DONE
    } load_state_t;
endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: packs a byte stream little-endian into NB_DATA-bit words
module imem_word_assembler
    import mips_mem_pkg::*;
(
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               byte_valid,
    input  logic [NBYTE-1:0]   byte_data,
    input  logic               clear,
    output logic               word_valid,
    output logic [NB_DATA-1:0] word
);
    localparam int NLANES = NB_DATA / NBYTE;
    localparam int LW = $clog2(NLANES);
    logic [LW-1:0] lane;
    assign word_valid = byte_valid && lane == LW'(NLANES - 1);
    always_ff @(posedge clock_i) begin
        if (!reset_i || clear) begin
            lane <= '0;
            word <= '0;
        end else if (byte_valid) begin
            lane <= word_valid ? '0 : lane + LW'(1);
            word[lane*NBYTE +: NBYTE] <= byte_data;
        end
    end
endmodule

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: owns the instruction-memory port; fetch pass-through in IDLE, UART program load otherwise
module imem_load_ctrl
    import mips_mem_pkg::*;
(
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [NBYTE-1:0]     rx_data_i,
    input  logic                 rx_done_i,
    input  logic                 load_start_i,
    input  logic                 fetch_en_i,
    input  logic [ADDRWIDTH-1:0] fetch_addr_i,
    output logic                 mem_en_write_o,
    output logic                 mem_en_read_o,
    output logic [ADDRWIDTH-1:0] mem_addr_o,
    output logic [NB_DATA-1:0]   mem_data_o,
    output logic                 load_busy_o,
    output logic                 load_done_o,
    output logic [ADDRWIDTH:0]   prog_len_o,
    output logic                 overflow_err_o
);
    load_state_t state, state_next;
    logic [ADDRWIDTH-1:0] wr_ptr;
    logic [NB_DATA-1:0] word;
    logic word_valid, is_halt, at_end, byte_valid, clear;
    assign clear = state == IDLE && load_start_i;
    assign is_halt = word == HALT_WORD;
    assign at_end = wr_ptr == ADDRWIDTH'(N_ELEMENTS - 1);
    // a byte landing in WRITE opens the next word only if the load continues
    assign byte_valid = rx_done_i && (state == LOAD || (state == WRITE && state_next == LOAD));
    imem_word_assembler u_asm (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .byte_valid (byte_valid),
        .byte_data  (rx_data_i),
        .clear      (clear),
        .word_valid (word_valid),
        .word       (word)
    );
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state <= IDLE;
            wr_ptr <= '0;
            prog_len_o <= '0;
            overflow_err_o <= 1'b0;
        end else begin
            state <= state_next;
            if (clear) begin
                wr_ptr <= '0;
                prog_len_o <= '0;
                overflow_err_o <= 1'b0;
            end
            if (state == WRITE) begin
                prog_len_o <= {1'b0, wr_ptr} + (ADDRWIDTH+1)'(1);
                if (!is_halt && at_end) overflow_err_o <= 1'b1;
                if (state_next == LOAD) wr_ptr <= wr_ptr + ADDRWIDTH'(1);
            end
        end
    end
    always_comb begin
        state_next = IDLE;
        if (state == IDLE) state_next = load_start_i ? LOAD : IDLE;
        if (state == LOAD) state_next = word_valid ? WRITE : LOAD;
        if (state == WRITE) state_next = (is_halt || at_end) ? DONE : LOAD;
        mem_en_read_o = state == IDLE && fetch_en_i;
        mem_en_write_o = state == WRITE;
        mem_addr_o = state == WRITE ? wr_ptr : state == IDLE ? fetch_addr_i : '0;
        mem_data_o = state == WRITE ? word : '0;
        load_busy_o = state == LOAD || state == WRITE;
        load_done_o = state == DONE;
    end
endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb_imem_load_ctrl: random byte-stream loads checked against a word-list model of the load protocol
module tb_imem_load_ctrl;
    import mips_mem_pkg::*;
    localparam int AW = ADDRWIDTH;
    logic clock_i = 1'b0;
    logic reset_i, rx_done_i, load_start_i, fetch_en_i;
    logic [7:0] rx_data_i;
    logic [AW-1:0] fetch_addr_i;
    logic mem_en_write_o, mem_en_read_o, load_busy_o, load_done_o, overflow_err_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [AW:0] prog_len_o;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [AW+31:0] wr_q[$];
    logic [7:0] bq[$];
    always #5 clock_i = ~clock_i;
    imem_load_ctrl dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .rx_data_i      (rx_data_i),
        .rx_done_i      (rx_done_i),
        .load_start_i   (load_start_i),
        .fetch_en_i     (fetch_en_i),
        .fetch_addr_i   (fetch_addr_i),
        .mem_en_write_o (mem_en_write_o),
        .mem_en_read_o  (mem_en_read_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .load_busy_o    (load_busy_o),
        .load_done_o    (load_done_o),
        .prog_len_o     (prog_len_o),
        .overflow_err_o (overflow_err_o)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    always @(negedge clock_i) begin
        if (mem_en_write_o) begin
            wr_q.push_back({mem_addr_o, mem_data_o});
            chk("rw_exclusive", 64'(mem_en_read_o), 64'd0);
        end
        if (load_done_o) done_cnt++;
        if (load_busy_o && fetch_en_i) chk("fetch_blocked", 64'(mem_en_read_o), 64'd0);
    end
    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data_i = b;
        rx_done_i = 1'b1;
        fetch_en_i = 1'($urandom);
        tick();
        rx_done_i = 1'b0;
        repeat (gap) tick();
    endtask
    task automatic add_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) bq.push_back(w[8*i +: 8]);
    endtask
    task automatic passthru();
        fetch_en_i = 1'($urandom);
        fetch_addr_i = AW'($urandom);
        #1;
        chk("pt_read", 64'(mem_en_read_o), 64'(fetch_en_i));
        chk("pt_addr", 64'(mem_addr_o), 64'(fetch_addr_i));
        chk("pt_write", 64'(mem_en_write_o), 64'd0);
        chk("pt_busy", 64'(load_busy_o), 64'd0);
    endtask
    // model: bytes form LE words in order; writes stop after HALT or a full memory, the rest is dropped
    task automatic run_load(input int gapmax, input int restart_at);
        logic [AW+31:0] exp_q[$];
        logic [31:0] w;
        logic halt;
        int n;
        halt = 1'b0;
        for (int i = 0; i + 3 < bq.size() && !halt && exp_q.size() < N_ELEMENTS; i += 4) begin
            w = {bq[i+3], bq[i+2], bq[i+1], bq[i]};
            exp_q.push_back({AW'(i / 4), w});
            halt = w == HALT_WORD;
        end
        wr_q.delete();
        done_cnt = 0;
        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
        foreach (bq[i]) begin
            load_start_i = i == restart_at;
            send_byte(bq[i], $urandom_range(gapmax));
            load_start_i = 1'b0;
        end
        n = 0;
        while ((load_busy_o || done_cnt == 0) && n < 50) begin
            tick();
            n++;
        end
        chk("done_timeout", 64'(n < 50), 64'd1);
        repeat (3) tick();
        chk("n_writes", 64'(wr_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) if (i < wr_q.size()) chk($sformatf("write%0d", i), 64'(wr_q[i]), 64'(exp_q[i]));
        chk("prog_len", 64'(prog_len_o), 64'(exp_q.size()));
        chk("overflow", 64'(overflow_err_o), 64'(!halt && exp_q.size() == N_ELEMENTS));
        chk("done_pulses", 64'(done_cnt), 64'd1);
        passthru();
        bq.delete();
    endtask
    initial begin
        reset_i = 1'b0;
        rx_done_i = 1'b0;
        rx_data_i = '0;
        load_start_i = 1'b0;
        fetch_en_i = 1'b0;
        fetch_addr_i = '0;
        repeat (3) tick();
        reset_i = 1'b1;
        tick();
        fetch_en_i = 1'b1;
        fetch_addr_i = AW'(5);
        #1;
        chk("rst_read", 64'(mem_en_read_o), 64'd1);
        chk("rst_addr", 64'(mem_addr_o), 64'd5);
        chk("rst_write", 64'(mem_en_write_o), 64'd0);
        chk("rst_busy", 64'(load_busy_o), 64'd0);
        chk("rst_prog_len", 64'(prog_len_o), 64'd0);
        chk("rst_overflow", 64'(overflow_err_o), 64'd0);
        chk("rst_done", 64'(load_done_o), 64'd0);
        add_word(32'h1234_5678);
        add_word(HALT_WORD);
        run_load(2, -1);
        add_word(32'h2001_0005);
        add_word(32'h0000_0000);
        add_word(HALT_WORD);
        run_load(0, -1);
        for (int i = 0; i < N_ELEMENTS; i++) add_word($urandom_range(32'hFFFF_FFFE));
        add_word(HALT_WORD);
        run_load(1, -1);
        wr_q.delete();
        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'(i + 1), 0);
        chk("pre_abort_writes", 64'(wr_q.size()), 64'd1);
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        chk("abort_busy", 64'(load_busy_o), 64'd0);
        chk("abort_prog_len", 64'(prog_len_o), 64'd0);
        chk("abort_overflow", 64'(overflow_err_o), 64'd0);
        passthru();
        add_word(32'h0000_0001);
        add_word(HALT_WORD);
        run_load(1, -1);
        wr_q.delete();
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1);
        chk("idle_rx_writes", 64'(wr_q.size()), 64'd0);
        chk("idle_rx_prog_len", 64'(prog_len_o), 64'd2);
        chk("idle_rx_busy", 64'(load_busy_o), 64'd0);
        add_word(32'hCAFE_0001);
        add_word(32'hCAFE_0002);
        add_word(HALT_WORD);
        run_load(1, 2);
        for (int t = 0; t < 8; t++) begin
            int nw;
            nw = $urandom_range(1, 8);
            for (int i = 0; i < nw; i++) add_word($urandom_range(32'hFFFF_FFFE));
            add_word(HALT_WORD);
            for (int i = $urandom_range(0, 5); i > 0; i--) bq.push_back(8'($urandom));
            run_load($urandom_range(0, 3), (t % 2 == 0) ? int'($urandom_range(0, 3)) : -1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
Controller that owns the instruction memory's write/read/address port. In RUN mode it passes pipeline fetch requests straight through to the memory. In LOAD mode it takes the program byte stream from the UART debug unit, packs it little-endian into 32-bit words and writes them to consecutive word addresses. Loading ends on a HALT word or when memory is full. Sits between the debug unit, the IF stage and the instruction memory.

Parameters:
NB_DATA, 32, instruction word width
NBYTE, 8, width of one received byte
N_ELEMENTS, 128, instruction memory depth in words
HALT_WORD, 32'hFFFF_FFFF, word that terminates a program load
ADDRWIDTH, $clog2(N_ELEMENTS), word-address width (derived; not overridden)

Ports:
clock_i  in  1  system clock; all state changes on the rising edge
reset_i  in  1  synchronous reset, active-low
rx_data_i  in  NBYTE  byte from the UART receiver
rx_done_i  in  1  one-cycle strobe: rx_data_i is valid
load_start_i  in  1  debug-unit command: begin program load
fetch_en_i  in  1  IF stage read request
fetch_addr_i  in  ADDRWIDTH  IF stage word address (PC >> 2)
mem_en_write_o  out  1  memory write enable
mem_en_read_o  out  1  memory read enable
mem_addr_o  out  ADDRWIDTH  memory word address
mem_data_o  out  NB_DATA  memory write data
load_busy_o  out  1  high while in LOAD or WRITE
load_done_o  out  1  one-cycle pulse when a load finishes
prog_len_o  out  ADDRWIDTH+1  number of words written by the last load, including the HALT word
overflow_err_o  out  1  last load filled memory without a HALT word; sticky until the next load_start

Behaviour:
- FSM states are IDLE, LOAD, WRITE and DONE. Reset (reset_i=0 at a clock edge) gives:
  - state=IDLE; byte counter=0; write pointer=0; word shift register=0;
  - prog_len_o=0, overflow_err_o=0, load_done_o=0.
- IDLE:
  - mem_en_read_o=fetch_en_i, mem_addr_o=fetch_addr_i (combinational pass-through, zero added latency);
  - mem_en_write_o=0, mem_data_o=0.
  - Read data comes back from the memory one cycle later; this block does not touch the read data.
  - rx_done_i is ignored.
  - load_start_i=1 → LOAD; clear byte counter, write pointer, prog_len_o and overflow_err_o.
- LOAD:
  - mem_en_read_o=0, mem_en_write_o=0; the fetch port is blocked.
  - Each rx_done_i places rx_data_i into byte lane [8k+7:8k], where k is the byte counter (0..3), then increments k.
  - When the 4th byte is accepted → WRITE, k=0.
  - load_start_i is ignored.
- WRITE (exactly one cycle):
  - mem_en_write_o=1, mem_addr_o=write pointer, mem_data_o=assembled word.
  - prog_len_o is updated to write pointer+1.
  - Word==HALT_WORD → DONE.
  - Otherwise, write pointer==N_ELEMENTS-1 → DONE and set overflow_err_o=1.
  - Otherwise → LOAD with write pointer+1.
  - An rx_done_i in this cycle is captured as byte 0 of the next word when returning to LOAD; it is dropped when going to DONE.
- DONE (one cycle):
  - load_done_o=1; all memory enables 0; → IDLE.
  - Bytes arriving in DONE or afterwards in IDLE are dropped.
- load_busy_o=1 in LOAD and WRITE, 0 otherwise.
- prog_len_o and overflow_err_o hold their value through IDLE until the next load_start_i.
- Reset in the middle of a load aborts it:
  - the partial word is discarded;
  - words already written stay in the memory;
  - all counters return to 0 and the next load starts at address 0.
- The write pointer never wraps; DONE is forced at N_ELEMENTS-1.
- The memory is never written and read in the same cycle.

Decomposition:
- Shared package (mips_mem_pkg): N_ELEMENTS, ADDRWIDTH, HALT_WORD and the FSM state encoding (2-bit localparams), shared with the instruction memory and the debug unit.
- One sub-module, imem_word_assembler:
  - contents: byte shift register and 2-bit byte counter;
  - inputs: byte strobe, data, clear;
  - outputs: word_valid pulse and the assembled word.
- The FSM and the port mux stay in imem_load_ctrl.

Test Plan:
1. Reset, then fetch_en_i=1, fetch_addr_i=5 → mem_en_read_o=1, mem_addr_o=5, mem_en_write_o=0, load_busy_o=0, prog_len_o=0.
2. load_start_i pulse, then bytes 78,56,34,12 → exactly one write cycle with addr=0, data=0x12345678. mem_en_read_o=0 from the first cycle of LOAD through WRITE.
3. Words 0x20010005, 0x00000000, then bytes FF×4 → writes to addr 0, 1, 2 (HALT at 2). Then load_done_o pulses once, prog_len_o=3, overflow_err_o=0, and the block returns to IDLE pass-through.
4. 128 non-HALT words → last write at addr 127, overflow_err_o=1, prog_len_o=128, load_done_o pulses. Four further bytes cause no write.
5. Reset asserted after 2 bytes of the second word → block is in IDLE with counters cleared. A new load of bytes 01,00,00,00 writes 0x00000001 to addr 0.
6. load_start_i pulsed during LOAD, and rx_done_i pulsed in IDLE → no state restart and no write. The write pointer and prog_len_o are unchanged.
